// File: rtl/lc3_addr_gen_if.sv
// Request/result bundle for the LC-3 effective-address generator.
// Defining ADDR_WRAP_FLAG_EN adds the ea_wrap result bit.
interface lc3_addr_gen_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] sr1;
    logic        addr1_sel;
    logic [1:0]  addr2_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ea_out;
`ifdef ADDR_WRAP_FLAG_EN
    logic        ea_wrap;

    modport master (
        output in_valid, ir, pc, sr1, addr1_sel, addr2_sel, out_ready,
        input  in_ready, out_valid, ea_out, ea_wrap
    );
    modport slave (
        input  in_valid, ir, pc, sr1, addr1_sel, addr2_sel, out_ready,
        output in_ready, out_valid, ea_out, ea_wrap
    );
`else
    modport master (
        output in_valid, ir, pc, sr1, addr1_sel, addr2_sel, out_ready,
        input  in_ready, out_valid, ea_out
    );
    modport slave (
        input  in_valid, ir, pc, sr1, addr1_sel, addr2_sel, out_ready,
        output in_ready, out_valid, ea_out
    );
`endif
endinterface

// File: rtl/lc3_addr_gen.sv
// Two-stage LC-3 effective-address generator (ADDR1MUX base + ADDR2MUX offset).
// Optional ADDR_WRAP_FLAG_EN registers a flag when the add wraps the address space.
module lc3_addr_gen #(
    parameter int          DATA_W = 16,
    parameter logic [15:0] EA_RST = 16'h0000
) (
    input logic          Clk,
    input logic          Reset,
    lc3_addr_gen_if.slave bus
);

    if (DATA_W != 16) begin : g_bad_width
        $error("lc3_addr_gen: only DATA_W=16 is supported");
    end

    logic              s1_v_q, s1_v_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] off_q,  off_d;
    logic              s2_v_q, s2_v_d;
    logic [DATA_W-1:0] ea_q,   ea_d;
    logic              s2_free_s;
    logic              in_ready_s;
    logic              accept_s;
    logic [DATA_W-1:0] off_sext_s;
    logic [DATA_W-1:0] sum_s;
`ifdef ADDR_WRAP_FLAG_EN
    logic              wrap_q, wrap_d;
    logic              wrap_s;
`endif

    assign s2_free_s  = !s2_v_q || bus.out_ready;
    assign in_ready_s = !s1_v_q || s2_free_s;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign sum_s      = base_q + off_q;
`ifdef ADDR_WRAP_FLAG_EN
    // A non-negative offset wraps when the sum drops below base; a negative one when it rises above.
    assign wrap_s = off_q[DATA_W-1] ? (sum_s > base_q) : (sum_s < base_q);
`endif

    // ADDR2MUX: sign-extend the selected IR offset field.
    always_comb begin
        off_sext_s = {DATA_W{1'b0}};
        case (bus.addr2_sel)
            2'b00:   off_sext_s = {DATA_W{1'b0}};
            2'b01:   off_sext_s = {{(DATA_W-6){bus.ir[5]}},   bus.ir[5:0]};
            2'b10:   off_sext_s = {{(DATA_W-9){bus.ir[8]}},   bus.ir[8:0]};
            2'b11:   off_sext_s = {{(DATA_W-11){bus.ir[10]}}, bus.ir[10:0]};
            default: off_sext_s = {DATA_W{1'b0}};
        endcase
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_v_d = s1_v_q;
        base_d = base_q;
        off_d  = off_q;
        s2_v_d = s2_v_q;
        ea_d   = ea_q;
`ifdef ADDR_WRAP_FLAG_EN
        wrap_d = wrap_q;
`endif
        if (accept_s) begin
            s1_v_d = 1'b1;
            base_d = bus.addr1_sel ? bus.sr1 : bus.pc;
            off_d  = off_sext_s;
        end else if (s1_v_q && s2_free_s) begin
            s1_v_d = 1'b0;
        end else begin
            s1_v_d = s1_v_q;
        end

        // S2 reloads whenever it is free; an empty S1 leaves a bubble and ea holds.
        if (s2_free_s) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                ea_d = sum_s;
`ifdef ADDR_WRAP_FLAG_EN
                wrap_d = wrap_s;
`endif
            end else begin
                ea_d = ea_q;
            end
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_v_q <= 1'b0;
            base_q <= EA_RST;
            off_q  <= EA_RST;
            s2_v_q <= 1'b0;
            ea_q   <= EA_RST;
`ifdef ADDR_WRAP_FLAG_EN
            wrap_q <= 1'b0;
`endif
        end else begin
            s1_v_q <= s1_v_d;
            base_q <= base_d;
            off_q  <= off_d;
            s2_v_q <= s2_v_d;
            ea_q   <= ea_d;
`ifdef ADDR_WRAP_FLAG_EN
            wrap_q <= wrap_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_v_q;
    assign bus.ea_out    = ea_q;
`ifdef ADDR_WRAP_FLAG_EN
    assign bus.ea_wrap   = wrap_q;
`endif

endmodule

// File: tb/tb_lc3_addr_gen.sv
// Directed-vector bench for lc3_addr_gen: table of single requests plus
// hand-written back-pressure, streaming and mid-operation reset sequences.
module tb_lc3_addr_gen;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    lc3_addr_gen_if bus ();

    lc3_addr_gen #(.DATA_W(16), .EA_RST(16'h0000)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] sr1;
        logic [15:0] ir;
        logic        a1;
        logic [1:0]  a2;
        logic [15:0] exp_ea;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_wrap(input string name, input logic exp);
`ifdef ADDR_WRAP_FLAG_EN
        chk(name, {31'd0, bus.ea_wrap}, {31'd0, exp});
`endif
    endtask

    initial begin
        vecs[0] = '{16'h3000, 16'h0000, 16'h0FFF, 1'b0, 2'b10, 16'h2FFF, 1'b0}; // BR backward
        vecs[1] = '{16'h0000, 16'h4000, 16'h6A3F, 1'b1, 2'b01, 16'h3FFF, 1'b0}; // LDR -1
        vecs[2] = '{16'h0100, 16'h0000, 16'h4BFF, 1'b0, 2'b11, 16'h04FF, 1'b0}; // JSR +max
        vecs[3] = '{16'h0100, 16'h0000, 16'h4C00, 1'b0, 2'b11, 16'hFD00, 1'b1}; // JSR -min
        vecs[4] = '{16'hAAAA, 16'h1234, 16'hFFFF, 1'b1, 2'b00, 16'h1234, 1'b0}; // zero offset
        vecs[5] = '{16'h3000, 16'h0000, 16'h001F, 1'b0, 2'b01, 16'h301F, 1'b0}; // offset6 +31
        vecs[6] = '{16'hFF80, 16'h0000, 16'h00FF, 1'b0, 2'b10, 16'h007F, 1'b1}; // +255 wraps

        bus.in_valid  = 1'b0;
        bus.ir        = 16'h0000;
        bus.pc        = 16'h0000;
        bus.sr1       = 16'h0000;
        bus.addr1_sel = 1'b0;
        bus.addr2_sel = 2'b00;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_ea_out", {16'd0, bus.ea_out}, 32'h0000);
        Reset = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk_wrap("rst_ea_wrap", 1'b0);

        // Single-request vectors: present in cycle 0, result visible in cycle 2.
        for (int i = 0; i < 7; i++) begin
            bus.pc        = vecs[i].pc;
            bus.sr1       = vecs[i].sr1;
            bus.ir        = vecs[i].ir;
            bus.addr1_sel = vecs[i].a1;
            bus.addr2_sel = vecs[i].a2;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            tick();
            bus.in_valid = 1'b0;
            bus.ir  = 16'h0000;
            bus.pc  = 16'h5555;
            bus.sr1 = 16'h5555;
            chk($sformatf("v%0d_c1_valid", i), {31'd0, bus.out_valid}, 32'd0);
            tick();
            chk($sformatf("v%0d_c2_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("v%0d_ea", i), {16'd0, bus.ea_out}, {16'd0, vecs[i].exp_ea});
            chk_wrap($sformatf("v%0d_wrap", i), vecs[i].exp_wrap);
            tick();
            chk($sformatf("v%0d_drained", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Back-to-back with back-pressure: bases 1..4 via sr1, zero offset.
        bus.addr1_sel = 1'b1;
        bus.addr2_sel = 2'b00;
        bus.in_valid  = 1'b1;
        bus.sr1       = 16'd1;
        bus.out_ready = 1'b1;
        tick();
        bus.sr1 = 16'd2;
        bus.out_ready = 1'b0;
        tick();
        bus.sr1 = 16'd3;
        #1;
        chk("bp_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_first_ea", {16'd0, bus.ea_out}, 32'd1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("bp_stall%0d_valid", c), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp_stall%0d_ea", c), {16'd0, bus.ea_out}, 32'd1);
            chk($sformatf("bp_stall%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("bp_ea2", {16'd0, bus.ea_out}, 32'd2);
        bus.sr1 = 16'd4;
        tick();
        chk("bp_ea3", {16'd0, bus.ea_out}, 32'd3);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_ea4", {16'd0, bus.ea_out}, 32'd4);
        chk("bp_ea4_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Full-throughput streaming from pc=FFFB, wrapping through 0000.
        bus.addr1_sel = 1'b0;
        bus.addr2_sel = 2'b00;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic [15:0] exp_ea;
            if (c >= 2) begin
                exp_ea = 16'hFFFB + 16'(c - 2);
                chk($sformatf("st%0d_valid", c), {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("st%0d_ea", c), {16'd0, bus.ea_out}, {16'd0, exp_ea});
            end else begin
                chk($sformatf("st%0d_idle", c), {31'd0, bus.out_valid}, 32'd0);
            end
            if (c < 10) begin
                bus.pc = 16'hFFFB + 16'(c);
                bus.in_valid = 1'b1;
                #1;
                chk($sformatf("st%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        chk("st_done", {31'd0, bus.out_valid}, 32'd0);

        // Reset with two requests in flight.
        bus.addr1_sel = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sr1       = 16'h1111;
        tick();
        bus.sr1 = 16'h2222;
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_ea", {16'd0, bus.ea_out}, 32'h1111);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_ea", {16'd0, bus.ea_out}, 32'h0000);
        #3;
        Reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", c), {31'd0, bus.out_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
